spi_eeprom_sched: RTL and testbench

Round-robin scheduler that shares the single SPI EEPROM read engine between NUM_REQ requesters. It accepts a (start address, word count) job from one requester, issues the engine's read, and assembles the engine's serial bit stream into 32-bit words. Each word goes to the owning requester. After the final word it cancels the engine and enforces a chip-select-high gap before the next job. It sits between the engine and on-chip consumers such as the checksum accumulator and a future loader.

---
 rtl/spi_eeprom_sched_pkg.sv | 14 +
 rtl/spi_eeprom_sched_rr_arbiter.sv | 40 ++++
 rtl/spi_eeprom_sched.sv | 117 +++++++++++
 tb/tb_spi_eeprom_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_eeprom_sched_pkg.sv
// Shared types and widths for the SPI EEPROM read scheduler.
package spi_eeprom_sched_pkg;
  localparam int ADDR_W = 24;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    STREAM,
    CANCEL,
    GAP
  } state_t;
endpackage

// File: rtl/spi_eeprom_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after last_grant+1.
// Grant is combinational; the pointer moves only on the advance strobe.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [IW-1:0] last;

  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    for (int i = N; i >= 1; i--) begin
      j = (int'(last) + i) % N;
      if (req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  // Pointer starts at N-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IW'(N - 1);
    end else if (advance) begin
      last <= grant_idx;
    end
  end
endmodule

// File: rtl/spi_eeprom_sched.sv
// Shares one SPI EEPROM read engine between NUM_REQ requesters, assembling
// the serial bit stream into 32-bit words for the owning requester.
module spi_eeprom_sched
  import spi_eeprom_sched_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        IN_req,
  input  logic [NUM_REQ*ADDR_W-1:0] IN_reqAddr,
  input  logic [NUM_REQ*LEN_W-1:0]  IN_reqLen,
  input  logic [NUM_REQ-1:0]        IN_reqAbort,
  output logic [NUM_REQ-1:0]        OUT_reqAck,
  output logic [WORD_W-1:0]         OUT_word,
  output logic [NUM_REQ-1:0]        OUT_wordValid,
  output logic [NUM_REQ-1:0]        OUT_done,
  output logic [ADDR_W-1:0]         OUT_eeAddr,
  output logic                      OUT_eeRead,
  output logic                      OUT_eeCancel,
  input  logic                      IN_eeData,
  input  logic                      IN_eeDataValid,
  input  logic                      IN_eeDataWord
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state, state_nxt;
  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       grant_idx;
  logic [IW-1:0]       owner;
  logic [NUM_REQ-1:0]  owner_oh;
  logic [LEN_W-1:0]    len_q, cnt, cnt_inc;
  logic [WORD_W-1:0]   sr, word_q;
  logic [NUM_REQ-1:0]  wvld_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          gap;
  logic                advance, abort_own, bit_vld, word_end, last_word, word_fire;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (IN_req),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign advance   = (state == IDLE) && (|IN_req);
  assign owner_oh  = NUM_REQ'(1) << owner;
  assign abort_own = IN_reqAbort[owner];
  assign cnt_inc   = cnt + 8'd1;
  assign bit_vld   = (state == STREAM) && IN_eeDataValid;
  assign word_end  = bit_vld && IN_eeDataWord;
  // 8-bit wrap makes a length of 0 complete after 256 words.
  assign last_word = word_end && (cnt_inc == len_q);
  // An abort coinciding with the final word still delivers it.
  assign word_fire = word_end && (!abort_own || last_word);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|IN_req) state_nxt = READ;
      READ:    state_nxt = abort_own ? CANCEL : STREAM;
      STREAM:  if (abort_own || last_word) state_nxt = CANCEL;
      CANCEL:  state_nxt = GAP;
      GAP:     if (gap <= 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign OUT_reqAck    = (state == IDLE) ? grant : '0;
  assign OUT_eeRead    = (state == READ);
  assign OUT_eeCancel  = (state == CANCEL);
  assign OUT_done      = (state == CANCEL) ? owner_oh : '0;
  assign OUT_word      = word_q;
  assign OUT_wordValid = wvld_q;
  assign OUT_eeAddr    = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      len_q  <= '0;
      cnt    <= '0;
      sr     <= '0;
      word_q <= '0;
      wvld_q <= '0;
      addr_q <= '0;
      gap    <= '0;
    end else begin
      state  <= state_nxt;
      wvld_q <= word_fire ? owner_oh : '0;
      case (state)
        IDLE: if (advance) begin
          owner  <= grant_idx;
          addr_q <= IN_reqAddr[int'(grant_idx)*ADDR_W +: ADDR_W];
          len_q  <= IN_reqLen[int'(grant_idx)*LEN_W +: LEN_W];
        end
        READ: begin
          sr  <= '0;
          cnt <= '0;
        end
        STREAM: if (bit_vld) begin
          sr <= {sr[WORD_W-2:0], IN_eeData};
          if (word_fire) begin
            word_q <= {sr[WORD_W-2:0], IN_eeData};
            cnt    <= cnt_inc;
          end
        end
        CANCEL:  gap <= 4'(GAP_CYCLES);
        GAP:     gap <= gap - 4'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_eeprom_sched.sv
// Scoreboard bench: an EEPROM/engine model streams memory words; expected acks,
// words and dones come from a round-robin + memory reference model.
module tb_spi_eeprom_sched;
  localparam int N   = 2;
  localparam int GAP = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0, abort = '0;
  logic [N*24-1:0] raddr = '0;
  logic [N*8-1:0]  rlen = '0;
  logic [N-1:0]    ack, wvld, done;
  logic [31:0]     word;
  logic [23:0]     ee_addr;
  logic            ee_read, ee_cancel;
  logic            ee_data = 1'b0, ee_dv = 1'b0, ee_dw = 1'b0;

  always #5 clk = ~clk;

  spi_eeprom_sched #(.NUM_REQ(N), .GAP_CYCLES(GAP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IN_req         (req),
    .IN_reqAddr     (raddr),
    .IN_reqLen      (rlen),
    .IN_reqAbort    (abort),
    .OUT_reqAck     (ack),
    .OUT_word       (word),
    .OUT_wordValid  (wvld),
    .OUT_done       (done),
    .OUT_eeAddr     (ee_addr),
    .OUT_eeRead     (ee_read),
    .OUT_eeCancel   (ee_cancel),
    .IN_eeData      (ee_data),
    .IN_eeDataValid (ee_dv),
    .IN_eeDataWord  (ee_dw)
  );

  int checks = 0, errs = 0, cyc = 0;
  int exp_ack[$], exp_wown[$], exp_done[$];
  logic [31:0] exp_word[$];
  int model_last = N - 1;
  int done_cnt = 0, wcnt = 0, last_cancel = -1, ack_cyc = -1;
  logic [23:0] ja[N];
  logic [7:0]  jl[N];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input int wa);
    if (wa == 32'h40) return 32'hDEADBEEF;
    if (wa == 32'h41) return 32'h01234567;
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic int model_pick(input logic [N-1:0] pend);
    for (int i = 1; i <= N; i++)
      if (pend[(model_last + i) % N]) return (model_last + i) % N;
    return -1;
  endfunction

  task automatic expect_job(input int idx, input int nwords_max);
    int n;
    n = (jl[idx] == 8'd0) ? 256 : int'(jl[idx]);
    if (nwords_max >= 0 && nwords_max < n) n = nwords_max;
    exp_ack.push_back(idx);
    for (int k = 0; k < n; k++) begin
      exp_word.push_back(mem_word(int'(ja[idx] >> 2) + k));
      exp_wown.push_back(idx);
    end
    exp_done.push_back(idx);
  endtask

  task automatic load_ports();
    for (int j = 0; j < N; j++) begin
      raddr[j*24 +: 24] = ja[j];
      rlen[j*8 +: 8]    = jl[j];
    end
  endtask

  // Engine + EEPROM model: after a read it streams memory words MSB first with
  // random bubbles until cancelled, then emits a few stray bits.
  initial begin
    logic rd, cn;
    logic [23:0] a;
    logic [31:0] w;
    bit run;
    int trail, wait_c, widx, bitp;
    run = 0; trail = 0; wait_c = 0; widx = 0; bitp = 31;
    forever begin
      @(negedge clk);
      rd = ee_read; cn = ee_cancel; a = ee_addr;
      @(posedge clk);
      #1;
      ee_dv = 1'b0; ee_dw = 1'b0; ee_data = 1'b0;
      if (!rst_n) begin
        run = 0; trail = 0;
      end else begin
        if (cn) begin run = 0; trail = 3; end
        if (rd) begin run = 1; wait_c = 4; widx = int'(a >> 2); bitp = 31; end
        if (run) begin
          if (wait_c > 0) wait_c--;
          else if ($urandom_range(0, 3) != 0) begin
            w = mem_word(widx);
            ee_dv = 1'b1; ee_data = w[bitp]; ee_dw = (bitp == 0);
            if (bitp == 0) begin bitp = 31; widx++; end
            else bitp--;
          end
        end else if (trail > 0) begin
          trail--; ee_dv = 1'b1; ee_dw = 1'b1; ee_data = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (|ack) begin
          if (exp_ack.size() == 0) chk("ack_unexpected", 32'(ack), 0);
          else chk("ack_grant", 32'(ack), 32'(1) << exp_ack.pop_front());
          ack_cyc = cyc;
        end
        if (ee_read) begin
          chk("read_after_ack", cyc - ack_cyc, 1);
          if (last_cancel >= 0) chk("gap_spacing", 32'(cyc - last_cancel >= GAP + 2), 1);
        end
        if (|wvld) begin
          wcnt++;
          if (exp_word.size() == 0) chk("word_unexpected", 32'(wvld), 0);
          else begin
            chk("word_owner", 32'(wvld), 32'(1) << exp_wown.pop_front());
            chk("word_data", word, exp_word.pop_front());
          end
        end
        if (ee_cancel) begin
          done_cnt++;
          last_cancel = cyc;
          if (exp_done.size() == 0) chk("done_unexpected", 32'(done), 0);
          else chk("done_with_cancel", 32'(done), 32'(1) << exp_done.pop_front());
        end else if (|done) chk("done_without_cancel", 32'(done), 0);
      end
    end
  end

  task automatic wait_ack(output logic [N-1:0] seen);
    int t;
    t = 0; seen = '0;
    while (t < 20000) begin
      @(negedge clk);
      if (|ack) begin seen = ack; break; end
      t++;
    end
    if (seen == '0) chk("ack_timeout", 0, 1);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 20000) begin @(negedge clk); t++; end
    chk("done_count", done_cnt, target);
    repeat (GAP + 4) @(negedge clk);
    chk("queue_drained", exp_word.size() + exp_done.size() + exp_ack.size(), 0);
  endtask

  task automatic wait_words(input int target);
    int t;
    t = 0;
    while (wcnt < target && t < 5000) begin @(negedge clk); t++; end
    if (wcnt < target) chk("word_timeout", wcnt, target);
  endtask

  task automatic run_batch(input logic [N-1:0] mask, input int njobs, input bit hold);
    logic [N-1:0] pend, seen;
    int got, d0, j;
    pend = mask;
    for (int k = 0; k < njobs; k++) begin
      j = model_pick(pend);
      model_last = j;
      expect_job(j, -1);
      if (!hold) pend[j] = 1'b0;
    end
    d0 = done_cnt; got = 0; pend = mask;
    load_ports();
    @(posedge clk); #1 req = mask;
    while (got < njobs) begin
      wait_ack(seen);
      if (seen == '0) break;
      got++;
      if (!hold) pend = pend & ~seen;
      @(posedge clk); #1 req = (got == njobs) ? '0 : pend;
    end
    req = '0;
    wait_done(d0 + njobs);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_wvld"}, 32'(wvld), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rd_cn"}, {30'd0, ee_read, ee_cancel}, 0);
    chk({tag, "_word"}, word, 0);
    chk({tag, "_addr"}, 32'(ee_addr), 0);
  endtask

  initial begin
    logic [N-1:0] seen;
    int d0, w0, idx;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    @(posedge clk); #2 rst_n = 1'b1;

    // Round-robin with both requests held: grants alternate from 0.
    ja[0] = 24'h001000; jl[0] = 8'd1;
    ja[1] = 24'h002000; jl[1] = 8'd1;
    run_batch(2'b11, 4, 1'b1);

    // Single directed job: DEADBEEF then 01234567.
    ja[0] = 24'h000100; jl[0] = 8'd2;
    run_batch(2'b01, 1, 1'b0);

    // Length 0 means 256 words.
    ja[1] = 24'h010000; jl[1] = 8'd0;
    run_batch(2'b10, 1, 1'b0);

    // Abort by owner part-way through word 3; non-owner abort ignored.
    ja[0] = 24'h003000; jl[0] = 8'd8;
    idx = model_pick(2'b01); model_last = idx;
    expect_job(0, 2);
    load_ports();
    d0 = done_cnt; w0 = wcnt;
    @(posedge clk); #1 req = 2'b01;
    wait_ack(seen);
    @(posedge clk); #1 req = '0;
    wait_words(w0 + 1);
    @(posedge clk); #1 abort = 2'b10;
    wait_words(w0 + 2);
    @(posedge clk); #1 abort = '0;
    repeat (10) @(posedge clk);
    #1 abort = 2'b01;
    @(posedge clk); #1 abort = '0;
    @(negedge clk);
    chk("abort_cancel_next", {31'd0, ee_cancel}, 1);
    chk("abort_done_next", 32'(done), 1);
    wait_done(d0 + 1);
    chk("abort_word_count", wcnt - w0, 2);

    // Random single-requester jobs.
    for (int r = 0; r < 6; r++) begin
      idx = $urandom_range(0, N - 1);
      ja[idx] = 24'($urandom_range(0, 24'h3FFFFF) * 4);
      jl[idx] = 8'($urandom_range(1, 3));
      run_batch(N'(1) << idx, 1, 1'b0);
    end

    // Reset mid-stream: outputs drop at once, requester 0 wins afterwards.
    ja[0] = 24'h004000; jl[0] = 8'd4;
    idx = model_pick(2'b01); model_last = idx;
    expect_job(0, -1);
    load_ports();
    w0 = wcnt;
    @(posedge clk); #1 req = 2'b01;
    wait_ack(seen);
    @(posedge clk); #1 req = '0;
    wait_words(w0 + 1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("midreset");
    exp_ack.delete(); exp_word.delete(); exp_wown.delete(); exp_done.delete();
    model_last = N - 1; last_cancel = -1;
    @(posedge clk); #2 rst_n = 1'b1;
    ja[0] = 24'h005000; jl[0] = 8'd1;
    ja[1] = 24'h006000; jl[1] = 8'd2;
    run_batch(2'b11, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
